// File: rtl/imm_gen_pipe_pkg.sv
// Shared LEGv8 opcode constants, immediate format codes and opcode-class helpers.
package imm_gen_pipe_pkg;

  // D format, iInstr[31:21]
  localparam logic [10:0] OPC_LDUR   = 11'b111_1100_0010;
  localparam logic [10:0] OPC_STUR   = 11'b111_1100_0000;
  localparam logic [10:0] OPC_LDURB  = 11'b001_1100_0010;
  localparam logic [10:0] OPC_STURB  = 11'b001_1100_0000;
  localparam logic [10:0] OPC_LDURH  = 11'b011_1100_0010;
  localparam logic [10:0] OPC_STURH  = 11'b011_1100_0000;
  localparam logic [10:0] OPC_LDURSW = 11'b101_1100_0100;
  localparam logic [10:0] OPC_STURW  = 11'b101_1100_0000;
  localparam logic [10:0] OPC_LDXR   = 11'b110_0100_0010;
  localparam logic [10:0] OPC_STXR   = 11'b110_0100_0000;
  localparam logic [10:0] OPC_LDURD  = 11'b111_1110_0010;
  localparam logic [10:0] OPC_STURD  = 11'b111_1110_0000;

  // I format, iInstr[31:22]
  localparam logic [9:0] OPC_ADDI  = 10'b10_0100_0100;
  localparam logic [9:0] OPC_ADDIS = 10'b10_1100_0100;
  localparam logic [9:0] OPC_SUBI  = 10'b11_0100_0100;
  localparam logic [9:0] OPC_SUBIS = 10'b11_1100_0100;
  localparam logic [9:0] OPC_ANDI  = 10'b10_0100_1000;
  localparam logic [9:0] OPC_ANDIS = 10'b11_1100_1000;
  localparam logic [9:0] OPC_ORRI  = 10'b10_1100_1000;
  localparam logic [9:0] OPC_EORI  = 10'b11_0100_1000;

  // IW format, iInstr[31:23]
  localparam logic [8:0] OPC_IW_MOVZ = 9'b1_1010_0101;
  localparam logic [8:0] OPC_IW_MOVK = 9'b1_1110_0101;

  // CB format, iInstr[31:24]
  localparam logic [7:0] OPC_CBZ   = 8'b1011_0100;
  localparam logic [7:0] OPC_CBNZ  = 8'b1011_0101;
  localparam logic [7:0] OPC_BCOND = 8'b0101_0100;

  // B format, iInstr[31:26]
  localparam logic [5:0] OPC_B = 6'b00_0101;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_D    = 3'd1,
    FMT_I    = 3'd2,
    FMT_B    = 3'd3,
    FMT_CB   = 3'd4,
    FMT_IW   = 3'd5
  } fmt_e;

  function automatic logic is_d_opc(input logic [10:0] opc);
    return opc inside {OPC_LDUR, OPC_STUR, OPC_LDURB, OPC_STURB, OPC_LDURH, OPC_STURH,
                       OPC_LDURSW, OPC_STURW, OPC_LDXR, OPC_STXR, OPC_LDURD, OPC_STURD};
  endfunction

  function automatic logic is_i_opc(input logic [9:0] opc);
    return opc inside {OPC_ADDI, OPC_ADDIS, OPC_SUBI, OPC_SUBIS,
                       OPC_ANDI, OPC_ANDIS, OPC_ORRI, OPC_EORI};
  endfunction

  function automatic logic is_iw_opc(input logic [8:0] opc);
    return opc inside {OPC_IW_MOVZ, OPC_IW_MOVK};
  endfunction

  function automatic logic is_cb_opc(input logic [7:0] opc);
    return opc inside {OPC_CBZ, OPC_CBNZ, OPC_BCOND};
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out stream with valid/ready on each side.
// slave is the block's view; master is the fetch/register-read side.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
);
  logic             iValid;
  logic             oReady;
  logic [31:0]      iInstr;
  logic [TAG_W-1:0] iTag;
  logic             oValid;
  logic             iReady;
  logic [XLEN-1:0]  oImm;
  logic [2:0]       oFmt;
  logic             oIllegal;
  logic [TAG_W-1:0] oTag;

  modport slave (
    input  iValid, iInstr, iTag, iReady,
    output oReady, oValid, oImm, oFmt, oIllegal, oTag
  );

  modport master (
    output iValid, iInstr, iTag, iReady,
    input  oReady, oValid, oImm, oFmt, oIllegal, oTag
  );
endinterface

// File: rtl/imm_gen_pipe_imm_decode.sv
// Combinational LEGv8 immediate decode to XLEN bits; zero latency, no handshake.
// Opcode classes do not overlap, so the if-chain order only expresses specificity.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [1:0]      hw;
  logic [XLEN-1:0] iw_base;
  logic            unused_bits;

  assign hw          = instr[22:21];
  assign iw_base     = {{(XLEN-16){1'b0}}, instr[20:5]};
  assign unused_bits = ^instr[4:0];

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (is_d_opc(instr[31:21])) begin
      fmt = FMT_D;
      imm = {{(XLEN-9){instr[20]}}, instr[20:12]};
    end else if (is_i_opc(instr[31:22])) begin
      fmt = FMT_I;
      imm = {{(XLEN-12){1'b0}}, instr[21:10]};
    end else if (is_iw_opc(instr[31:23])) begin
      fmt = FMT_IW;
      // At 32 bits the upper two halfword slots do not exist.
      if (XLEN == 32 && hw[1]) illegal = 1'b1;
      else                     imm = iw_base << {hw, 4'b0000};
    end else if (is_cb_opc(instr[31:24])) begin
      fmt = FMT_CB;
      imm = {{(XLEN-21){instr[23]}}, instr[23:5], 2'b00};
    end else if (instr[31:26] == OPC_B) begin
      fmt = FMT_B;
      imm = {{(XLEN-28){instr[25]}}, instr[25:0], 2'b00};
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-entry (output reg R + skid reg S) pipelined immediate generator; 1-cycle latency.
// oReady is a flop (~S.valid next), so upstream never sees a path from iReady.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
) (
  input logic         iCLK,
  input logic         iRST,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic             vld;
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t          r_q, r_d, s_q, s_d, dec_e;
  logic            rdy_q;
  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_ill;
  logic            accept, drain;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (bus.iInstr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  assign dec_e  = '{vld: 1'b1, imm: dec_imm, fmt: dec_fmt, ill: dec_ill, tag: bus.iTag};
  assign accept = bus.iValid & rdy_q;
  assign drain  = r_q.vld & bus.iReady;

  always_comb begin
    r_d = r_q;
    s_d = s_q;
    if (!r_q.vld || drain) begin
      if (s_q.vld)     r_d = s_q;
      else if (accept) r_d = dec_e;
      else             r_d = '0;
    end
    if (s_q.vld && drain) begin
      s_d = accept ? dec_e : '0;
    end else if (accept && r_q.vld && !drain) begin
      // Only reachable with S empty, since rdy_q is low whenever S is full.
      s_d = dec_e;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_q   <= '0;
      s_q   <= '0;
      rdy_q <= 1'b1;
    end else begin
      r_q   <= r_d;
      s_q   <= s_d;
      rdy_q <= ~s_d.vld;
    end
  end

  assign bus.oReady   = rdy_q;
  assign bus.oValid   = r_q.vld;
  assign bus.oImm     = r_q.imm;
  assign bus.oFmt     = r_q.fmt;
  assign bus.oIllegal = r_q.ill;
  assign bus.oTag     = r_q.tag;

endmodule
